rd_add_arbiter: RTL and testbench

Round-robin arbiter and sequencer sharing one 4-stage pipelined 8-bit recursive-doubling CLA adder (rd8p) among NREQ requesters.
Grants at most one operand pair per cycle, registers it into the adder, and carries a valid/ID tag down a shadow pipeline matched to adder latency.
Returns each result with the originating requester ID.
Sits between requester blocks and the shared rd8p instance at the level above.

---
 rtl/rd_add_pkg.sv | 24 ++
 rtl/rr_arb_onehot.sv | 40 ++++
 rtl/rd_add_arbiter.sv | 155 +++++++++++++++
 tb/tb_rd_add_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rd_add_pkg.sv
// Shared constants and the shadow-pipeline tag type for the rd8p adder front end.
package rd_add_pkg;

    localparam int ADD_W   = 8;
    localparam int RD_LAT  = 4;
    localparam int MAX_REQ = 8;
    localparam int TAG_IDW = 3;

    // Wide enough for the largest supported requester count; narrower IDs zero-extend.
    typedef struct packed {
        logic               valid;
        logic [TAG_IDW-1:0] id;
    } tag_t;

    localparam tag_t TAG_NONE = '0;

    function automatic tag_t make_tag(input logic [TAG_IDW-1:0] id);
        tag_t t;
        t.valid = 1'b1;
        t.id    = id;
        return t;
    endfunction

endpackage

// File: rtl/rr_arb_onehot.sv
// Round-robin pick: the first asserted request at or above the pointer, wrapping to bit 0.
module rr_arb_onehot
    import rd_add_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);

    if (NREQ < 1 || NREQ > MAX_REQ) begin : g_bad_nreq
        $error("rr_arb_onehot: NREQ out of range");
    end

    // Two passes: requesters at/above the pointer first, then the wrapped ones below it.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!any_o && req_i[i] && (i >= int'(ptr_i))) begin
                any_o      = 1'b1;
                grant_o[i] = 1'b1;
                idx_o      = IDW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!any_o && req_i[i] && (i < int'(ptr_i))) begin
                any_o      = 1'b1;
                grant_o[i] = 1'b1;
                idx_o      = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/rd_add_arbiter.sv
// Shares one pipelined rd8p adder among NREQ requesters: one grant per cycle, and each
// result comes back LAT+1 cycles after acceptance tagged with the requester that issued it.
module rd_add_arbiter
    import rd_add_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int LAT  = RD_LAT,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [ADD_W*NREQ-1:0] req_a,
    input  logic [ADD_W*NREQ-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  hold,
    output logic [ADD_W-1:0]      add_a,
    output logic [ADD_W-1:0]      add_b,
    input  logic [ADD_W-1:0]      add_sum,
    input  logic                  add_carry,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic [ADD_W-1:0]      rsp_sum,
    output logic                  rsp_carry,
    output logic [3:0]            in_flight,
    output logic                  idle
);

    logic [NREQ-1:0]    reqElig;
    logic [NREQ-1:0]    grant;
    logic [IDW-1:0]     grantIdx;
    logic               grantAny;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [ADD_W-1:0]   selA, selB;
    logic [ADD_W-1:0]   addA_q, addB_q;
    tag_t               tag_d;
    tag_t               tag_q [LAT+1];
    logic               retire;
    logic               rspValid_q;
    logic [IDW-1:0]     rspId_q;
    logic [ADD_W-1:0]   rspSum_q;
    logic               rspCarry_q;
    logic [3:0]         inFlight_q, inFlight_d;
    logic [TAG_IDW-1:0] unusedTagId;

    // Reset and drain mode both suppress grants combinationally.
    assign reqElig = (hold || reset) ? '0 : req_valid;

    rr_arb_onehot #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req_i   (reqElig),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (grantIdx),
        .any_o   (grantAny)
    );

    assign req_ready = grant;

    always_comb begin
        selA = '0;
        selB = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                selA = req_a[i*ADD_W +: ADD_W];
                selB = req_b[i*ADD_W +: ADD_W];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grantAny) begin
            ptr_d = (grantIdx == IDW'(NREQ - 1)) ? '0 : grantIdx + 1'b1;
        end
    end

    assign tag_d  = grantAny ? make_tag(TAG_IDW'(grantIdx)) : TAG_NONE;
    assign retire = tag_q[LAT].valid;

    // An op stops counting on the edge its response strobe is raised, so a grant
    // and a retirement on the same edge cancel out.
    always_comb begin
        inFlight_d = inFlight_q;
        if (grantAny && !retire) begin
            inFlight_d = inFlight_q + 4'd1;
        end else if (!grantAny && retire) begin
            inFlight_d = inFlight_q - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q      <= '0;
            inFlight_q <= '0;
            addA_q     <= '0;
            addB_q     <= '0;
        end else begin
            ptr_q      <= ptr_d;
            inFlight_q <= inFlight_d;
            if (grantAny) begin
                addA_q <= selA;
                addB_q <= selB;
            end
        end
    end

    // The adder has no enable, so the tag shadow shifts unconditionally to stay aligned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k <= LAT; k++) begin
                tag_q[k] <= TAG_NONE;
            end
        end else begin
            tag_q[0] <= tag_d;
            for (int k = 1; k <= LAT; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rspValid_q <= 1'b0;
            rspId_q    <= '0;
            rspSum_q   <= '0;
            rspCarry_q <= 1'b0;
        end else begin
            rspValid_q <= retire;
            if (retire) begin
                rspId_q    <= tag_q[LAT].id[IDW-1:0];
                rspSum_q   <= add_sum;
                rspCarry_q <= add_carry;
            end
        end
    end

    assign unusedTagId = tag_q[LAT].id;

    assign add_a     = addA_q;
    assign add_b     = addB_q;
    assign rsp_valid = rspValid_q;
    assign rsp_id    = rspId_q;
    assign rsp_sum   = rspSum_q;
    assign rsp_carry = rspCarry_q;
    assign in_flight = inFlight_q;
    assign idle      = (inFlight_q == '0) && (req_valid == '0);

    assert property (@(posedge clk) disable iff (reset) $onehot0(req_ready));
    assert property (@(posedge clk) disable iff (reset) (req_ready & ~req_valid) == '0);
    assert property (@(posedge clk) disable iff (reset) inFlight_q <= 4'(LAT + 1));

endmodule

// File: tb/tb_rd_add_arbiter.sv
// Bench for rd_add_arbiter: a behavioural 4-stage adder stub plus a queue-based model
// of round-robin grants and in-order tagged responses.
module tb_rd_add_arbiter;

    localparam int NREQ = 4;
    localparam int LAT  = 4;
    localparam int IDW  = 2;

    typedef struct {
        int         id;
        logic [8:0] res;
        int         due;
    } exp_t;

    logic                clk;
    logic                reset;
    logic [NREQ-1:0]     req_valid;
    logic [8*NREQ-1:0]   req_a;
    logic [8*NREQ-1:0]   req_b;
    logic [NREQ-1:0]     req_ready;
    logic                hold;
    logic [7:0]          add_a;
    logic [7:0]          add_b;
    logic [7:0]          add_sum;
    logic                add_carry;
    logic                rsp_valid;
    logic [IDW-1:0]      rsp_id;
    logic [7:0]          rsp_sum;
    logic                rsp_carry;
    logic [3:0]          in_flight;
    logic                idle;

    logic [7:0] opA [NREQ];
    logic [7:0] opB [NREQ];
    logic [8:0] addPipe [LAT];

    int checks = 0;
    int passes = 0;

    exp_t            expQ[$];
    int              mdlPtr;
    int              mdlInflight;
    int              cyc;
    logic [8:0]      lastRes;
    int              grantIdx;
    logic [NREQ-1:0] expReady, obsReady;
    logic            expRv, obsRv;
    int              expId, obsId;
    logic [8:0]      expRes, obsRes;
    int              expIf, obsIf;

    rd_add_arbiter #(.NREQ(NREQ), .LAT(LAT), .IDW(IDW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .hold      (hold),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum),
        .add_carry (add_carry),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry),
        .in_flight (in_flight),
        .idle      (idle)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_pack
        assign req_a[g*8 +: 8] = opA[g];
        assign req_b[g*8 +: 8] = opB[g];
    end

    // Stand-in for the shared rd8p: LAT registered stages, cleared by the same reset.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < LAT; k++) addPipe[k] <= '0;
        end else begin
            addPipe[0] <= {1'b0, add_a} + {1'b0, add_b};
            for (int k = 1; k < LAT; k++) addPipe[k] <= addPipe[k-1];
        end
    end
    assign {add_carry, add_sum} = addPipe[LAT-1];

    function automatic int refGrant(input logic [NREQ-1:0] v, input logic h, input int ptr);
        int j;
        if (h) return -1;
        for (int k = 0; k < NREQ; k++) begin
            j = (ptr + k) % NREQ;
            if (v[2'(j)]) return j;
        end
        return -1;
    endfunction

    task automatic modelReset();
        expQ.delete();
        mdlPtr      = 0;
        mdlInflight = 0;
        lastRes     = '0;
    endtask

    // One clock: drive at the falling edge, predict and sample the grant, then sample
    // the registered outputs just after the rising edge.
    task automatic step(input logic [NREQ-1:0] v, input logic h);
        req_valid = v;
        hold      = h;
        #1;
        grantIdx = refGrant(v, h, mdlPtr);
        expReady = '0;
        if (grantIdx >= 0) expReady[2'(grantIdx)] = 1'b1;
        obsReady = req_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (grantIdx >= 0) begin
            expQ.push_back('{grantIdx,
                             {1'b0, opA[2'(grantIdx)]} + {1'b0, opB[2'(grantIdx)]},
                             cyc + LAT + 1});
            mdlPtr = (grantIdx + 1) % NREQ;
            mdlInflight++;
        end
        expRv = 1'b0;
        expId = 0;
        if (expQ.size() > 0 && expQ[0].due == cyc) begin
            expRv   = 1'b1;
            expId   = expQ[0].id;
            lastRes = expQ[0].res;
            void'(expQ.pop_front());
            mdlInflight--;
        end
        expRes = lastRes;
        expIf  = mdlInflight;
        obsRv  = rsp_valid;
        obsId  = int'(rsp_id);
        obsRes = {rsp_carry, rsp_sum};
        obsIf  = int'(in_flight);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        hold      = 1'b0;
        req_valid = 4'hF;
        for (int i = 0; i < NREQ; i++) begin
            opA[i] = 8'h00;
            opB[i] = 8'h00;
        end
        cyc = 0;
        modelReset();
        #3;
        checks++; if (req_ready !== 4'b0000) $display("FAIL reset_ready got=%b want=0000", req_ready); else passes++;
        checks++; if ({rsp_valid, rsp_carry, rsp_id, rsp_sum} !== 12'h000)
            $display("FAIL reset_rsp got=%b%b%h%h want=0", rsp_valid, rsp_carry, rsp_id, rsp_sum); else passes++;
        checks++; if ({add_a, add_b} !== 16'h0000) $display("FAIL reset_add got=%h%h want=0000", add_a, add_b); else passes++;
        checks++; if (in_flight !== 4'd0) $display("FAIL reset_inflight got=%0d want=0", in_flight); else passes++;
        req_valid = 4'h0;
        #1;
        checks++; if (idle !== 1'b1) $display("FAIL reset_idle got=%b want=1", idle); else passes++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single_op();
        opA[2] = 8'hFF;
        opB[2] = 8'h01;
        step(4'b0100, 1'b0);
        checks++; if (obsReady !== 4'b0100) $display("FAIL single_ready got=%b want=0100", obsReady); else passes++;
        checks++; if (obsIf !== 1) $display("FAIL single_inflight got=%0d want=1", obsIf); else passes++;
        for (int k = 1; k <= 7; k++) begin
            step(4'b0000, 1'b0);
            checks++; if (obsRv !== (k == 5)) $display("FAIL single_strobe step=%0d got=%b want=%b", k, obsRv, (k == 5)); else passes++;
            if (k == 5) begin
                checks++; if (obsId !== 2 || obsRes !== 9'h100)
                    $display("FAIL single_result got id=%0d res=%h want id=2 res=100", obsId, obsRes); else passes++;
            end
            checks++; if (obsIf !== expIf) $display("FAIL single_inflight step=%0d got=%0d want=%0d", k, obsIf, expIf); else passes++;
        end
        checks++; if (idle !== 1'b1) $display("FAIL single_idle got=%b want=1", idle); else passes++;
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < NREQ; i++) begin
            opA[i] = 8'(i);
            opB[i] = 8'h10;
        end
        for (int k = 0; k < 12 + LAT + 2; k++) begin
            step((k < 12) ? 4'hF : 4'h0, 1'b0);
            checks++; if (obsReady !== expReady) $display("FAIL rr_ready cyc=%0d got=%b want=%b", cyc, obsReady, expReady); else passes++;
            checks++; if (obsRv !== expRv) $display("FAIL rr_strobe cyc=%0d got=%b want=%b", cyc, obsRv, expRv); else passes++;
            if (expRv) begin
                checks++; if (obsId !== expId) $display("FAIL rr_id cyc=%0d got=%0d want=%0d", cyc, obsId, expId); else passes++;
            end
            checks++; if (obsRes !== expRes) $display("FAIL rr_result cyc=%0d got=%h want=%h", cyc, obsRes, expRes); else passes++;
            checks++; if (obsIf !== expIf) $display("FAIL rr_inflight cyc=%0d got=%0d want=%0d", cyc, obsIf, expIf); else passes++;
        end
    endtask

    task automatic test_pointer();
        opA[1] = 8'h21; opB[1] = 8'h02;
        opA[3] = 8'h7F; opB[3] = 8'h81;
        step(4'b1000, 1'b0);
        checks++; if (obsReady !== 4'b1000) $display("FAIL ptr_first got=%b want=1000", obsReady); else passes++;
        step(4'b1010, 1'b0);
        checks++; if (obsReady !== 4'b0010) $display("FAIL ptr_wrap got=%b want=0010", obsReady); else passes++;
        step(4'b1000, 1'b0);
        checks++; if (obsReady !== 4'b1000) $display("FAIL ptr_next got=%b want=1000", obsReady); else passes++;
        for (int k = 0; k < LAT + 2; k++) begin
            step(4'b0000, 1'b0);
            checks++; if (obsRv !== expRv || (expRv && obsId !== expId) || obsRes !== expRes)
                $display("FAIL ptr_rsp cyc=%0d got v=%b id=%0d res=%h want v=%b id=%0d res=%h",
                         cyc, obsRv, obsId, obsRes, expRv, expId, expRes); else passes++;
        end
        checks++; if (obsRes !== 9'h100) $display("FAIL ptr_last_sum got=%h want=100", obsRes); else passes++;
    endtask

    task automatic test_hold();
        int seen = 0;
        for (int i = 0; i < NREQ; i++) begin
            opA[i] = 8'h30 + 8'(i);
            opB[i] = 8'hC8;
        end
        for (int k = 0; k < 3; k++) step(4'hF, 1'b0);
        checks++; if (obsIf !== 3) $display("FAIL hold_inflight got=%0d want=3", obsIf); else passes++;
        for (int k = 0; k < 9; k++) begin
            step((k < 3) ? 4'hF : 4'h0, 1'b1);
            if (obsRv) seen++;
            checks++; if (obsReady !== 4'b0000) $display("FAIL hold_ready cyc=%0d got=%b want=0000", cyc, obsReady); else passes++;
            checks++; if (obsRv !== expRv || (expRv && obsId !== expId) || obsRes !== expRes)
                $display("FAIL hold_rsp cyc=%0d got v=%b id=%0d res=%h want v=%b id=%0d res=%h",
                         cyc, obsRv, obsId, obsRes, expRv, expId, expRes); else passes++;
        end
        checks++; if (seen !== 3) $display("FAIL hold_count got=%0d want=3", seen); else passes++;
        checks++; if (idle !== 1'b1 || in_flight !== 4'd0) $display("FAIL hold_idle got idle=%b n=%0d want idle=1 n=0", idle, in_flight); else passes++;
        hold = 1'b0;
    endtask

    task automatic test_reset_mid();
        int stale = 0;
        for (int i = 0; i < NREQ; i++) begin
            opA[i] = 8'h40 + 8'(i);
            opB[i] = 8'h05;
        end
        for (int k = 0; k < 4; k++) step(4'hF, 1'b0);
        checks++; if (obsIf !== 4) $display("FAIL rstmid_inflight got=%0d want=4", obsIf); else passes++;
        #2;
        reset = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0000) $display("FAIL rstmid_ready got=%b want=0000", req_ready); else passes++;
        checks++; if ({rsp_valid, rsp_carry, rsp_sum, add_a, add_b, in_flight} !== 30'd0)
            $display("FAIL rstmid_zero got v=%b c=%b s=%h a=%h b=%h n=%0d want 0",
                     rsp_valid, rsp_carry, rsp_sum, add_a, add_b, in_flight); else passes++;
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        for (int k = 0; k < 8; k++) begin
            step(4'h0, 1'b0);
            if (obsRv) stale++;
        end
        checks++; if (stale !== 0) $display("FAIL rstmid_stale got=%0d want=0", stale); else passes++;
        step(4'b1010, 1'b0);
        checks++; if (obsReady !== 4'b0010) $display("FAIL rstmid_first got=%b want=0010", obsReady); else passes++;
        for (int k = 0; k < LAT + 2; k++) begin
            step(4'h0, 1'b0);
            checks++; if (obsRv !== expRv || (expRv && obsId !== expId) || obsRes !== expRes || obsIf !== expIf)
                $display("FAIL rstmid_rsp cyc=%0d got v=%b id=%0d res=%h n=%0d want v=%b id=%0d res=%h n=%0d",
                         cyc, obsRv, obsId, obsRes, obsIf, expRv, expId, expRes, expIf); else passes++;
        end
    endtask

    task automatic test_random();
        logic [NREQ-1:0] v;
        logic            h;
        int              accepted = 0;
        int              guard = 0;
        v = '0;
        while (accepted < 1000 && guard < 6000) begin
            for (int r = 0; r < 3; r++) begin
                if (!v[2'(r)] && $urandom_range(3) != 0) begin
                    v[2'(r)] = 1'b1;
                    opA[2'(r)] = 8'($urandom);
                    opB[2'(r)] = 8'($urandom);
                end
            end
            h = ($urandom_range(7) == 0);
            step(v, h);
            checks++; if (obsReady !== expReady) $display("FAIL rand_ready cyc=%0d got=%b want=%b", cyc, obsReady, expReady); else passes++;
            checks++; if (obsRv !== expRv || (expRv && obsId !== expId) || obsRes !== expRes)
                $display("FAIL rand_rsp cyc=%0d got v=%b id=%0d res=%h want v=%b id=%0d res=%h",
                         cyc, obsRv, obsId, obsRes, expRv, expId, expRes); else passes++;
            checks++; if (obsIf !== expIf || obsIf > LAT + 1)
                $display("FAIL rand_inflight cyc=%0d got=%0d want=%0d", cyc, obsIf, expIf); else passes++;
            if (grantIdx >= 0) begin
                accepted++;
                v[2'(grantIdx)] = 1'b0;
            end
            guard++;
        end
        checks++; if (accepted !== 1000) $display("FAIL rand_budget got=%0d want=1000", accepted); else passes++;
        for (int k = 0; k < LAT + 2; k++) begin
            step(4'h0, 1'b0);
            checks++; if (obsRv !== expRv || (expRv && obsId !== expId) || obsRes !== expRes)
                $display("FAIL rand_drain cyc=%0d got v=%b id=%0d res=%h want v=%b id=%0d res=%h",
                         cyc, obsRv, obsId, obsRes, expRv, expId, expRes); else passes++;
        end
        checks++; if (expQ.size() !== 0 || in_flight !== 4'd0)
            $display("FAIL rand_left got n=%0d queued=%0d want 0", in_flight, expQ.size()); else passes++;
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_round_robin();
        test_pointer();
        test_hold();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
